// File: rtl/deser_arbiter.sv
// rtl/deser_arbiter.sv - round-robin arbiter sharing one deserializer between N serial lanes
//
// Ports:
//   clk_i, arstn_i            clock, asynchronous active-low reset
//   req_i[N]                  per-lane request level, sampled only while idle
//   data_i[N], data_val_i[N]  per-lane serial bit and bit-valid
//   gnt_o[N]                  one-hot grant of the lane being forwarded
//   ser_data_o, ser_data_val_o     granted lane's bit stream towards the deserializer
//   deser_data_i, deser_data_val_i parallel word and strobe back from the deserializer
//   word_o, word_lane_o, word_val_o captured word, its source lane, one-cycle strobe
//   err_o                     one-cycle pulse when the deserializer never answered
module deser_arbiter #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64,
    localparam int LW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          arstn_i,
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  data_i,
    input  logic [N-1:0]  data_val_i,
    output logic [N-1:0]  gnt_o,
    output logic          ser_data_o,
    output logic          ser_data_val_o,
    input  logic [W-1:0]  deser_data_i,
    input  logic          deser_data_val_i,
    output logic [W-1:0]  word_o,
    output logic [LW-1:0] word_lane_o,
    output logic          word_val_o,
    output logic          err_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [LW-1:0]   last_q, last_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [W-1:0]    word_d;
    logic [LW-1:0]   word_lane_d;
    logic            word_val_d;
    logic            err_d;
    logic            pick_found;
    logic [LW-1:0]   pick_lane;

    function automatic logic [LW-1:0] lane_at(input logic [LW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N;
        return LW'(s);
    endfunction

    // Scan from the farthest candidate down to last+1 so the nearest
    // requester after the previous winner is the one that sticks.
    always_comb begin
        pick_found = 1'b0;
        pick_lane  = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[lane_at(last_q, k)]) begin
                pick_found = 1'b1;
                pick_lane  = lane_at(last_q, k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        last_d      = last_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        word_d      = word_o;
        word_lane_d = word_lane_o;
        word_val_d  = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    lane_d    = pick_lane;
                    bit_cnt_d = '0;
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                if (data_val_i[lane_q]) begin
                    if (bit_cnt_q == CW'(W - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = S_WAIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // A word arriving on the last allowed cycle still wins over the abort.
                if (deser_data_val_i) begin
                    word_d      = deser_data_i;
                    word_lane_d = lane_q;
                    word_val_d  = 1'b1;
                    last_d      = lane_q;
                    state_d     = S_IDLE;
                end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    last_d  = lane_q;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            last_q      <= LW'(N - 1);
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            word_o      <= '0;
            word_lane_o <= '0;
            word_val_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            last_q      <= last_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            word_o      <= word_d;
            word_lane_o <= word_lane_d;
            word_val_o  <= word_val_d;
            err_o       <= err_d;
        end
    end

    // Grant is decoded from the registered state so it drops the instant
    // reset is asserted, without waiting for a clock.
    assign gnt_o          = (state_q == S_GRANT) ? (N'(1) << lane_q) : '0;
    assign ser_data_o     = (state_q == S_GRANT) && data_i[lane_q];
    assign ser_data_val_o = (state_q == S_GRANT) && data_val_i[lane_q];

endmodule

// File: tb/tb_deser_arbiter.sv
// tb/tb_deser_arbiter.sv - self-checking bench for deser_arbiter with a behavioural deserializer
module tb_deser_arbiter;

    localparam int N       = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 64;
    localparam int LW      = 2;

    logic          clk = 1'b0;
    logic          arstn;
    logic [N-1:0]  req, din, dval;
    logic [N-1:0]  gnt;
    logic          ser_d, ser_v;
    logic [W-1:0]  deser_d;
    logic          deser_v_m, spur, stub;
    logic          deser_v;
    logic [W-1:0]  word;
    logic [LW-1:0] word_lane;
    logic          word_val, err;

    always #5 clk = ~clk;
    assign deser_v = deser_v_m | spur;

    deser_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i            (clk),
        .arstn_i          (arstn),
        .req_i            (req),
        .data_i           (din),
        .data_val_i       (dval),
        .gnt_o            (gnt),
        .ser_data_o       (ser_d),
        .ser_data_val_o   (ser_v),
        .deser_data_i     (deser_d),
        .deser_data_val_i (deser_v),
        .word_o           (word),
        .word_lane_o      (word_lane),
        .word_val_o       (word_val),
        .err_o            (err)
    );

    // Behavioural deserializer: MSB-first shift, word strobed the cycle after the W-th bit.
    logic [W-1:0] sh;
    int           bcnt;
    always @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sh <= '0; bcnt <= 0; deser_v_m <= 1'b0; deser_d <= '0;
        end else begin
            deser_v_m <= 1'b0;
            if (ser_v) begin
                sh <= {sh[W-2:0], ser_d};
                if (bcnt == W - 1) begin
                    bcnt <= 0;
                    if (!stub) begin
                        deser_v_m <= 1'b1;
                        deser_d   <= {sh[W-2:0], ser_d};
                    end
                end else begin
                    bcnt <= bcnt + 1;
                end
            end
        end
    end

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] lane_word [N];
    int           model_last;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic wait_grant(output int lane, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (gnt == '0 && n < 20);
        lane = 0;
        for (int k = 0; k < N; k++) if (gnt[k]) lane = k;
    endtask

    // Sends nbits valid bits of lane_word[lane] with random gaps, optional noise on other lanes.
    task automatic send_bits(input int lane, input int nbits, input int drop_at, input bit noise);
        int           i   = 0;
        int           cyc = 0;
        logic         v;
        logic [W-1:0] w   = lane_word[lane];
        while (i < nbits && cyc < 400) begin
            v    = ($urandom_range(0, 3) != 0);
            dval = noise ? 4'($urandom) : '0;
            din  = noise ? 4'($urandom) : '0;
            dval[lane] = v;
            din[lane]  = v ? w[W-1-i] : 1'($urandom);
            #1;
            check("ser_val_track", {31'b0, ser_v}, {31'b0, v});
            if (v) check("ser_data", {31'b0, ser_d}, {31'b0, w[W-1-i]});
            @(posedge clk); #1; cyc++;
            if (v) i++;
            if (drop_at >= 0 && i >= drop_at) req[lane] = 1'b0;
            if (i < W) check("gnt_held", {28'b0, gnt}, 32'(1 << lane));
        end
        if (cyc >= 400) begin
            checks++; errors++;
            $display("FAIL send_bound actual=%0d bits expected=%0d bits", i, nbits);
        end
    endtask

    task automatic run_grant(input logic [N-1:0] r, input int exp_lane, input int drop_at,
                             input bit noise, input bit exp_err);
        int lane, n;
        req = r;
        wait_grant(lane, n);
        check("grant_latency", n, 1);
        check("grant_lane", {28'b0, gnt}, 32'(1 << exp_lane));
        check("no_pulse_in_grant", {30'b0, word_val, err}, 0);
        if (gnt == '0) begin
            req = '0;
            return;
        end
        send_bits(lane, W, drop_at, noise);
        dval = '1;
        din  = 4'($urandom);
        #1;
        check("gnt_drop_after_last_bit", {28'b0, gnt}, 0);
        check("ser_val_zero_in_wait", {31'b0, ser_v}, 0);
        dval = '0;
        din  = '0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!word_val && !err && n < TIMEOUT + 8);
        if (exp_err) begin
            check("timeout_err", {31'b0, err}, 1);
            check("timeout_no_word", {31'b0, word_val}, 0);
            check("timeout_cycles", n, TIMEOUT);
        end else begin
            check("word_val", {31'b0, word_val}, 1);
            check("word_no_err", {31'b0, err}, 0);
            check("word_latency", n, 1);
            check("word_data", {16'b0, word}, {16'b0, lane_word[exp_lane]});
            check("word_lane", {30'b0, word_lane}, 32'(exp_lane));
        end
        check("idle_gap", {28'b0, gnt}, 0);
        req = '0;
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           drop_at;
        bit           noise;
        bit           exp_err;
        int           exp_lane;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{4'b0001, -1, 1'b0, 1'b0, 0};
        tbl[1] = '{4'b1111, -1, 1'b0, 1'b0, 1};
        tbl[2] = '{4'b1111, -1, 1'b0, 1'b0, 2};
        tbl[3] = '{4'b1111, -1, 1'b0, 1'b0, 3};
        tbl[4] = '{4'b1111, -1, 1'b0, 1'b0, 0};
        tbl[5] = '{4'b1111, -1, 1'b0, 1'b0, 1};
        tbl[6] = '{4'b0100,  5, 1'b0, 1'b0, 2};
        tbl[7] = '{4'b0010, -1, 1'b1, 1'b0, 1};
        tbl[8] = '{4'b1111, -1, 1'b0, 1'b1, 2};
        tbl[9] = '{4'b1111, -1, 1'b0, 1'b0, 3};
        lane_word[0] = 16'hA5C3;
        lane_word[1] = 16'h1E2D;
        lane_word[2] = 16'h3C4B;
        lane_word[3] = 16'h5A69;

        arstn = 1'b0; req = '1; din = '0; dval = '1; spur = 1'b0; stub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {28'b0, gnt}, 0);
        check("rst_ser_v", {31'b0, ser_v}, 0);
        check("rst_word", {16'b0, word}, 0);
        check("rst_word_lane", {30'b0, word_lane}, 0);
        check("rst_pulses", {30'b0, word_val, err}, 0);
        req = '0; dval = '0;
        arstn = 1'b1;
        model_last = N - 1;
        @(posedge clk); #1;

        for (int e = 0; e < 10; e++) begin
            stub = tbl[e].exp_err;
            run_grant(tbl[e].req, tbl[e].exp_lane, tbl[e].drop_at, tbl[e].noise, tbl[e].exp_err);
            stub = 1'b0;
            model_last = tbl[e].exp_lane;
        end

        // Deserializer strobe while idle must be ignored.
        req = '0;
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        check("spur_idle_gnt", {28'b0, gnt}, 0);
        @(posedge clk); #1;
        check("spur_idle_pulses", {30'b0, word_val, err}, 0);

        for (int r = 0; r < 12; r++) begin
            logic [N-1:0] rq;
            int           ex, drop;
            bit           st, nz;
            rq = 4'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) lane_word[k] = 16'($urandom);
            ex   = rr_pick(model_last, rq);
            st   = ($urandom_range(0, 5) == 0);
            nz   = 1'($urandom);
            drop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
            stub = st;
            run_grant(rq, ex, drop, nz, st);
            stub = 1'b0;
            model_last = ex;
        end

        // Asynchronous reset in the middle of lane 1's word.
        begin
            int lane, n;
            req = 4'b0010;
            wait_grant(lane, n);
            check("mid_rst_grant", {28'b0, gnt}, 32'b0010);
            send_bits(1, 8, -1, 1'b0);
            dval = '1;
            #2;
            arstn = 1'b0;
            #1;
            check("mid_rst_gnt", {28'b0, gnt}, 0);
            check("mid_rst_ser_v", {31'b0, ser_v}, 0);
            check("mid_rst_word", {16'b0, word}, 0);
            check("mid_rst_word_lane", {30'b0, word_lane}, 0);
            check("mid_rst_pulses", {30'b0, word_val, err}, 0);
            dval = '0;
            req = '0;
            #3;
            arstn = 1'b1;
            model_last = N - 1;
            run_grant(4'b1111, rr_pick(model_last, 4'b1111), -1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
